// File: rtl/prog_rom_responder.sv
// prog_rom_responder: nibble-wide program ROM with a same-cycle fetch read port and a byte-wide valid/ready loader.
// Define ROM_PARITY_EN to store an even-parity bit per nibble and expose parity_err / par_inject.
module prog_rom_responder #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rom_select,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        rom_data,
    output logic              rom_ready,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
`ifdef ROM_PARITY_EN
    output logic              load_done,
    output logic              parity_err,
    input  logic              par_inject
`else
    output logic              load_done
`endif
);
`ifdef ROM_PARITY_EN
    localparam int MW = 5;
`else
    localparam int MW = 4;
`endif
    typedef enum logic [1:0] {IDLE, ACCEPT, WR_HI, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [3:0]        hi_q, hi_d;
    logic              we;
    logic [3:0]        wnib;
    logic [MW-1:0]     wentry, rd;
    logic [MW-1:0]     mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        case (state_q)
            IDLE: if (load_start) begin
                wr_ptr_d = load_base;
                rem_d    = load_count;
                state_d  = (load_count == '0) ? DONE : ACCEPT;
            end
            ACCEPT: if (load_valid) begin
                hi_d     = load_byte[7:4];
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                state_d  = WR_HI;
            end
            WR_HI: begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                rem_d    = rem_q - CNT_W'(1);
                state_d  = (rem_q == CNT_W'(1)) ? DONE : ACCEPT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rom_ready  = state_q == IDLE;
        load_ready = state_q == ACCEPT;
        load_done  = state_q == DONE;
        we         = (state_q == ACCEPT && load_valid) || state_q == WR_HI;
        wnib       = (state_q == WR_HI) ? hi_q : load_byte[3:0];
    end

`ifdef ROM_PARITY_EN
    assign wentry     = {^wnib ^ par_inject, wnib};
    assign parity_err = rom_select && rom_ready && ((^rd[3:0]) != rd[4]);
`else
    assign wentry = wnib;
`endif

    // Reset wins over a pending write so a byte cut off in WR_HI loses its high nibble.
    always_ff @(posedge clk) begin
        if (we && !reset) mem[wr_ptr_q] <= wentry;
    end

    assign rd       = mem[rom_addr];
    assign rom_data = (rom_select && rom_ready) ? rd[3:0] : 4'h0;
endmodule

// File: tb/tb_prog_rom_responder.sv
// tb_prog_rom_responder: directed loads followed by a table of read vectors, plus handshake corner sequences.
module tb_prog_rom_responder;
    logic        clk = 0;
    logic        reset = 1;
    logic        rom_select = 0;
    logic [11:0] rom_addr = '0;
    logic [3:0]  rom_data;
    logic        rom_ready;
    logic        load_start = 0;
    logic [11:0] load_base = '0;
    logic [11:0] load_count = '0;
    logic        load_valid = 0;
    logic [7:0]  load_byte = '0;
    logic        load_ready;
    logic        load_done;
`ifdef ROM_PARITY_EN
    logic        parity_err;
    logic        par_inject = 0;
`endif
    int checks = 0;
    int errors = 0;
    logic [7:0] lb[$];

    typedef struct {
        logic        sel;
        logic [11:0] addr;
        logic [3:0]  exp;
    } vec_t;
    vec_t vt[18];

    prog_rom_responder dut (
        .clk(clk), .reset(reset), .rom_select(rom_select), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ready(rom_ready), .load_start(load_start),
        .load_base(load_base), .load_count(load_count), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready),
`ifdef ROM_PARITY_EN
        .load_done(load_done), .parity_err(parity_err), .par_inject(par_inject)
`else
        .load_done(load_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [11:0] base, input logic [11:0] cnt);
        int w;
        load_start = 1; load_base = base; load_count = cnt;
        tick;
        load_start = 0;
        foreach (lb[i]) begin
            load_valid = 1; load_byte = lb[i];
            #1;
            w = 0;
            while (!load_ready && w < 8) begin tick; #1; w++; end
            if (!load_ready) chk("ready_timeout", {31'b0, load_ready}, 1);
            tick;
            load_valid = 0;
        end
        #1;
        w = 0;
        while (!load_done && w < 8) begin tick; #1; w++; end
        chk("load_done_seen", {31'b0, load_done}, 1);
        tick;
    endtask

    initial begin
        logic [7:0] d3[3];
        logic       exp_rdy[6];
        int         k;
        vt = '{
            '{1, 12'h010, 4'h5}, '{1, 12'h011, 4'hA}, '{1, 12'h012, 4'hC}, '{1, 12'h013, 4'h3},
            '{0, 12'h010, 4'h0}, '{0, 12'h013, 4'h0},
            '{1, 12'h100, 4'h1}, '{1, 12'h101, 4'h1}, '{1, 12'h102, 4'h2}, '{1, 12'h103, 4'h2},
            '{1, 12'h104, 4'h3}, '{1, 12'h105, 4'h3}, '{1, 12'h106, 4'h9}, '{1, 12'h107, 4'h9},
            '{1, 12'hFFF, 4'hE}, '{1, 12'h000, 4'h7}, '{1, 12'h200, 4'h4}, '{1, 12'h201, 4'h6}
        };
        d3 = '{8'h11, 8'h22, 8'h33};
        exp_rdy = '{1, 0, 1, 0, 1, 0};

        tick; tick;
        reset = 0;
        #1;
        chk("rst_rom_ready", {31'b0, rom_ready}, 1);
        chk("rst_load_ready", {31'b0, load_ready}, 0);
        chk("rst_load_done", {31'b0, load_done}, 0);

        // Burst of two bytes with explicit per-cycle handshake checks.
        load_start = 1; load_base = 12'h010; load_count = 12'd2;
        tick;
        load_start = 0; load_valid = 1; load_byte = 8'hA5;
        #1;
        chk("t1_acc_ready", {31'b0, load_ready}, 1);
        chk("t1_acc_romrdy", {31'b0, rom_ready}, 0);
        tick;
        load_valid = 0;
        #1;
        chk("t1_wrhi_ready", {31'b0, load_ready}, 0);
        chk("t1_wrhi_romrdy", {31'b0, rom_ready}, 0);
        tick;
        load_valid = 1; load_byte = 8'h3C;
        #1;
        chk("t1_acc2_ready", {31'b0, load_ready}, 1);
        tick;
        load_valid = 0;
        tick;
        chk("t1_done", {31'b0, load_done}, 1);
        chk("t1_done_romrdy", {31'b0, rom_ready}, 0);
        tick;
        chk("t1_done_pulse", {31'b0, load_done}, 0);
        chk("t1_idle_romrdy", {31'b0, rom_ready}, 1);

        lb = '{8'h99};
        do_load(12'h106, 12'd1);

        // Valid held high throughout; reads during the burst must return zero.
        rom_select = 1; rom_addr = 12'h010;
        load_start = 1; load_base = 12'h100; load_count = 12'd3;
        tick;
        load_start = 0; load_valid = 1; k = 0; load_byte = d3[0];
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_ready_%0d", i), {31'b0, load_ready}, {31'b0, exp_rdy[i]});
            chk($sformatf("t3_rd_zero_%0d", i), {28'b0, rom_data}, 0);
            if (load_ready) k++;
            tick;
            load_byte = (k < 3) ? d3[k] : 8'h44;
        end
        chk("t3_done", {31'b0, load_done}, 1);
        tick;
        chk("t3_done_pulse", {31'b0, load_done}, 0);
        tick; tick;
        load_valid = 0; rom_select = 0;

        lb = '{8'h7E};
        do_load(12'hFFF, 12'd1);

        // Zero-length burst goes straight to DONE.
        load_start = 1; load_base = 12'h010; load_count = 12'd0;
        tick;
        load_start = 0;
        chk("t5_zero_done", {31'b0, load_done}, 1);
        chk("t5_zero_romrdy", {31'b0, rom_ready}, 0);
        tick;
        chk("t5_zero_pulse", {31'b0, load_done}, 0);

        lb = '{8'h66};
        do_load(12'h200, 12'd1);
        load_start = 1; load_base = 12'h200; load_count = 12'd2;
        tick;
        load_start = 0; load_valid = 1; load_byte = 8'hB4;
        tick;
        load_valid = 0; reset = 1;
        tick;
        reset = 0;
        #1;
        chk("t5_rst_romrdy", {31'b0, rom_ready}, 1);
        chk("t5_rst_ready", {31'b0, load_ready}, 0);
        chk("t5_rst_done", {31'b0, load_done}, 0);
        tick;
        chk("t5_rst_nodone", {31'b0, load_done}, 0);

        foreach (vt[i]) begin
            rom_select = vt[i].sel; rom_addr = vt[i].addr;
            #1;
            chk($sformatf("rd_%03h_sel%0d", vt[i].addr, vt[i].sel), {28'b0, rom_data}, {28'b0, vt[i].exp});
        end
        rom_select = 0;

`ifdef ROM_PARITY_EN
        tick;
        par_inject = 1;
        lb = '{8'h21};
        do_load(12'h300, 12'd1);
        par_inject = 0;
        rom_select = 1; rom_addr = 12'h300;
        #1;
        chk("par_inj_err", {31'b0, parity_err}, 1);
        chk("par_inj_data", {28'b0, rom_data}, 1);
        rom_select = 0;
        lb = '{8'h21};
        do_load(12'h300, 12'd1);
        rom_select = 1; rom_addr = 12'h300;
        #1;
        chk("par_clean_err", {31'b0, parity_err}, 0);
        rom_addr = 12'h301;
        #1;
        chk("par_clean_hi", {31'b0, parity_err}, 0);
        rom_select = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
